// File: rtl/serial_frame_rx.sv
// serial_frame_rx: rebuilds MSB-first serial frames sampled on clkTx rising edges and splits them into fields.
// Optional SERIAL_RX_STATS_EN adds saturating good-frame and error counters.
module serial_frame_rx #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clkTx,
  input  logic                 dIn,
  input  logic                 dInValid,
  output logic                 busy,
  output logic                 frameValid,
  output logic                 frameErr,
  output logic [3*WIDTH+7:0]   frameData,
  output logic [WIDTH-1:0]     opA,
  output logic [WIDTH-1:0]     opB,
  output logic [WIDTH-1:0]     result,
  output logic [3:0]           sel,
  output logic [3:0]           flags
`ifdef SERIAL_RX_STATS_EN
  ,
  output logic [15:0]          frameCount,
  output logic [7:0]           errCount
`endif
);
  localparam int FRAME_W = 3*WIDTH+8;
  localparam int CW = $clog2(FRAME_W+1);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DRAIN = 2'd2;
  logic [1:0] state, state_n;
  // only FRAME_W-1 bits of history are needed: the last bit completes the word directly
  logic [FRAME_W-2:0] sr, sr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [FRAME_W-1:0] data_n;
  logic clk_tx_q, rise, valid_n, err_n, extra, extra_n;
  assign rise = clkTx & ~clk_tx_q;
  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    data_n  = frameData;
    valid_n = 1'b0;
    err_n   = 1'b0;
    extra_n = extra;
    case (state)
      IDLE: if (rise && dInValid) begin
        sr_n    = {{(FRAME_W-2){1'b0}}, dIn};
        cnt_n   = CW'(1);
        state_n = SHIFT;
      end
      SHIFT: if (!dInValid) begin
        err_n   = 1'b1;
        cnt_n   = '0;
        state_n = IDLE;
      end else if (rise) begin
        sr_n  = {sr[FRAME_W-3:0], dIn};
        cnt_n = cnt + CW'(1);
        if (cnt_n == CW'(FRAME_W)) begin
          data_n  = {sr, dIn};
          valid_n = 1'b1;
          extra_n = 1'b0;
          state_n = DRAIN;
        end
      end
      DRAIN: if (!dInValid) begin
        extra_n = 1'b0;
        state_n = IDLE;
      end else if (rise && !extra) begin
        err_n   = 1'b1;
        extra_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      frameData  <= '0;
      clk_tx_q   <= 1'b0;
      extra      <= 1'b0;
      busy       <= 1'b0;
      frameValid <= 1'b0;
      frameErr   <= 1'b0;
    end else begin
      state      <= state_n;
      sr         <= sr_n;
      cnt        <= cnt_n;
      frameData  <= data_n;
      clk_tx_q   <= clkTx;
      extra      <= extra_n;
      busy       <= state_n != IDLE;
      frameValid <= valid_n;
      frameErr   <= err_n;
    end
  end
`ifdef SERIAL_RX_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frameCount <= '0;
      errCount   <= '0;
    end else begin
      frameCount <= (valid_n && frameCount != '1) ? frameCount + 16'd1 : frameCount;
      errCount   <= (err_n && errCount != '1) ? errCount + 8'd1 : errCount;
    end
  end
`endif
  assign opA    = frameData[FRAME_W-1 -: WIDTH];
  assign opB    = frameData[FRAME_W-1-WIDTH -: WIDTH];
  assign result = frameData[8 +: WIDTH];
  assign sel    = frameData[7:4];
  assign flags  = frameData[3:0];
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: randomized serial frames checked against a per-transaction frame/error model.
module tb_serial_frame_rx;
  logic clk = 1'b0;
  logic reset, clkTx, dIn, dInValid;
  logic busy, frameValid, frameErr;
  logic [31:0] frameData;
  logic [7:0] opA, opB, result;
  logic [3:0] sel, flags;
`ifdef SERIAL_RX_STATS_EN
  logic [15:0] frameCount;
  logic [7:0] errCount;
`endif
  int compared = 0, failed = 0;
  logic [31:0] got_q[$], exp_q[$];
  int got_err = 0, exp_err = 0, wide = 0;
  logic fv_q = 1'b0, fe_q = 1'b0;

  serial_frame_rx #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .clkTx(clkTx), .dIn(dIn), .dInValid(dInValid),
    .busy(busy), .frameValid(frameValid), .frameErr(frameErr), .frameData(frameData),
    .opA(opA), .opB(opB), .result(result), .sel(sel), .flags(flags)
`ifdef SERIAL_RX_STATS_EN
    , .frameCount(frameCount), .errCount(errCount)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frameValid) got_q.push_back(frameData);
    if (frameErr) got_err++;
    if ((frameValid && fv_q) || (frameErr && fe_q)) wide++;
    fv_q = frameValid;
    fe_q = frameErr;
  end

  // a transaction of n bits yields a frame of its first 32 bits when n>=32, and one error unless n==32
  function automatic void model(input logic [63:0] bits, input int n);
    if (n >= 32) exp_q.push_back(32'(bits >> (n - 32)));
    if (n > 0 && n != 32) exp_err++;
  endfunction

  task automatic clear_model();
    got_q.delete();
    exp_q.delete();
    got_err = 0;
    exp_err = 0;
    wide = 0;
  endtask

  task automatic send_bits(input logic [63:0] bits, input int n, input int ratio, input bit drop);
    int lo = ratio / 2;
    int hi = ratio - lo;
    dInValid = 1'b1;
    for (int i = n - 1; i >= 0; i--) begin
      dIn = bits[i];
      clkTx = 1'b0;
      repeat (lo) @(negedge clk);
      clkTx = 1'b1;
      repeat (hi) @(negedge clk);
    end
    clkTx = 1'b0;
    if (drop) begin
      dInValid = 1'b0;
      dIn = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    dInValid = 1'b0;
    dIn = 1'b0;
    for (int i = 0; i < n; i++) begin
      clkTx = ~clkTx;
      @(negedge clk);
    end
    clkTx = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if ({busy, frameValid, frameErr} !== 3'b000) begin
      failed++; $display("FAIL reset_flags: got %b want 000", {busy, frameValid, frameErr});
    end
    compared++;
    if ({frameData, opA, opB, result, sel, flags} !== '0) begin
      failed++; $display("FAIL reset_data: got %h want 0", frameData);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [63:0] b;
    clear_model();
    send_bits(64'hA53CE12F, 32, 4, 1'b1);
    model(64'hA53CE12F, 32);
    idle(3);
    compared++;
    if (got_q.size() !== exp_q.size()) begin
      failed++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      compared++;
      if (got_q[0] !== exp_q[0]) begin
        failed++; $display("FAIL basic_word: got %h want %h", got_q[0], exp_q[0]);
      end
    end
    compared++;
    if ({opA, opB, result, sel, flags} !== 32'hA53CE12F) begin
      failed++; $display("FAIL basic_fields: got %h %h %h %h %h want a5 3c e1 2 f", opA, opB, result, sel, flags);
    end
    compared++;
    if (busy !== 1'b0 || got_err !== exp_err || wide !== 0) begin
      failed++; $display("FAIL basic_tail: busy %b err %0d wide %0d want 0 %0d 0", busy, got_err, exp_err, wide);
    end
    clear_model();
    b = {32'h0, $urandom};
    send_bits(b, 10, 4, 1'b1);
    model(b, 10);
    idle(3);
    compared++;
    if (got_q.size() !== exp_q.size() || got_err !== exp_err || wide !== 0) begin
      failed++; $display("FAIL abort_pulses: frames %0d err %0d wide %0d want %0d %0d 0", got_q.size(), got_err, wide, exp_q.size(), exp_err);
    end
    compared++;
    if (frameData !== 32'hA53CE12F) begin
      failed++; $display("FAIL abort_hold: got %h want a53ce12f", frameData);
    end
  endtask

  task automatic test_overrun();
    clear_model();
    send_bits(64'h1_FFFF_FFFF, 33, 3, 1'b1);
    model(64'h1_FFFF_FFFF, 33);
    idle(3);
    compared++;
    if (got_q.size() !== exp_q.size() || got_err !== exp_err || wide !== 0) begin
      failed++; $display("FAIL overrun_pulses: frames %0d err %0d wide %0d want %0d %0d 0", got_q.size(), got_err, wide, exp_q.size(), exp_err);
    end else begin
      compared++;
      if (got_q[0] !== exp_q[0]) begin
        failed++; $display("FAIL overrun_word: got %h want %h", got_q[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_model();
    send_bits(64'h00000001, 32, 2, 1'b1);
    model(64'h00000001, 32);
    idle(1);
    send_bits(64'h80000000, 32, 2, 1'b1);
    model(64'h80000000, 32);
    idle(3);
    compared++;
    if (got_q.size() !== exp_q.size() || got_err !== exp_err) begin
      failed++; $display("FAIL b2b_count: frames %0d err %0d want %0d %0d", got_q.size(), got_err, exp_q.size(), exp_err);
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        compared++;
        if (got_q[i] !== exp_q[i]) begin
          failed++; $display("FAIL b2b_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    send_bits({32'h0, $urandom}, 16, 4, 1'b0);
    compared++;
    if (busy !== 1'b1) begin
      failed++; $display("FAIL mid_busy: got %b want 1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if ({busy, frameValid, frameErr, frameData, opA, opB, result, sel, flags} !== '0) begin
      failed++; $display("FAIL mid_reset_outputs: busy %b data %h want 0", busy, frameData);
    end
    dInValid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_model();
    send_bits(64'h12345678, 32, 4, 1'b1);
    model(64'h12345678, 32);
    idle(3);
    compared++;
    if (got_q.size() !== exp_q.size() || got_err !== exp_err) begin
      failed++; $display("FAIL mid_after_count: frames %0d err %0d want %0d %0d", got_q.size(), got_err, exp_q.size(), exp_err);
    end else begin
      compared++;
      if (got_q[0] !== exp_q[0]) begin
        failed++; $display("FAIL mid_after_word: got %h want %h", got_q[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_random();
    clear_model();
    for (int t = 0; t < 16; t++) begin
      logic [63:0] b;
      int n, r;
      b = {$urandom, $urandom};
      r = $urandom_range(0, 3);
      n = (r < 2) ? 32 : (r == 2) ? $urandom_range(33, 40) : $urandom_range(1, 31);
      send_bits(b, n, $urandom_range(2, 6), 1'b1);
      model(b, n);
      idle($urandom_range(1, 3));
    end
    idle(3);
    compared++;
    if (got_q.size() !== exp_q.size() || got_err !== exp_err || wide !== 0) begin
      failed++; $display("FAIL rand_count: frames %0d err %0d wide %0d want %0d %0d 0", got_q.size(), got_err, wide, exp_q.size(), exp_err);
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        compared++;
        if (got_q[i] !== exp_q[i]) begin
          failed++; $display("FAIL rand_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

`ifdef SERIAL_RX_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      send_bits({32'h0, $urandom}, 32, 2, 1'b1);
      idle(1);
    end
    for (int i = 0; i < 2; i++) begin
      send_bits({32'h0, $urandom}, $urandom_range(1, 31), 2, 1'b1);
      idle(1);
    end
    idle(2);
    compared++;
    if (frameCount !== 16'd3 || errCount !== 8'd2) begin
      failed++; $display("FAIL stats_counts: got %0d %0d want 3 2", frameCount, errCount);
    end
    for (int i = 0; i < 256; i++) begin
      send_bits(64'h1, 1, 2, 1'b1);
      idle(1);
    end
    idle(2);
    compared++;
    if (errCount !== 8'hFF || frameCount !== 16'd3) begin
      failed++; $display("FAIL stats_saturate: got %h %0d want ff 3", errCount, frameCount);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    clkTx = 1'b0;
    dIn = 1'b0;
    dInValid = 1'b0;
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_random();
`ifdef SERIAL_RX_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
